// File: rtl/ddr_request_arbiter_if.sv
// rtl/ddr_request_arbiter_if.sv - requester and DDR command handshake bundle for ddr_request_arbiter
interface ddr_request_arbiter_if #(
  parameter int ADDR_W = 24,
  parameter int DATA_W = 32
);
  // display read requester
  logic              rd_req;
  logic [ADDR_W-1:0] rd_addr;
  logic              rd_gnt;
  logic              rd_done;
  // pixel write requester
  logic              wr_req;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic              wr_gnt;
  logic              wr_done;
  // DDR command engine port
  logic              cmd_valid;
  logic              cmd_ready;
  logic [1:0]        cmd_op;
  logic [ADDR_W-1:0] cmd_addr;
  logic [DATA_W-1:0] cmd_wdata;
  logic              cmd_done;

  // arbiter side
  modport master (
    input  rd_req, rd_addr, wr_req, wr_addr, wr_data, cmd_ready, cmd_done,
    output rd_gnt, rd_done, wr_gnt, wr_done, cmd_valid, cmd_op, cmd_addr, cmd_wdata
  );

  // requesters and DDR engine side
  modport slave (
    output rd_req, rd_addr, wr_req, wr_addr, wr_data, cmd_ready, cmd_done,
    input  rd_gnt, rd_done, wr_gnt, wr_done, cmd_valid, cmd_op, cmd_addr, cmd_wdata
  );
endinterface

// File: rtl/ddr_request_arbiter.sv
// rtl/ddr_request_arbiter.sv - DDR command port arbiter (read/write/refresh); optional DDR_ARB_STARVE_GUARD_EN
module ddr_request_arbiter #(
  parameter int ADDR_W         = 24,
  parameter int DATA_W         = 32,
  parameter int REFRESH_CYCLES = 1040,
  parameter int MAX_PEND       = 8,
  parameter int STARVE_LIMIT   = 16
) (
  input  logic                   clk133_p_i,
  input  logic                   rst_i,
  input  logic                   init_done_i,
  ddr_request_arbiter_if.master  bus_if,
  output logic [3:0]             ref_pend_o
);

  localparam int                TMR_W      = $clog2(REFRESH_CYCLES);
  localparam logic [TMR_W-1:0]  TMR_RELOAD = TMR_W'(REFRESH_CYCLES - 1);
  localparam logic [3:0]        PEND_MAX   = 4'(MAX_PEND);
  localparam logic [1:0]        OP_RD      = 2'b00;
  localparam logic [1:0]        OP_WR      = 2'b01;
  localparam logic [1:0]        OP_REF     = 2'b10;

  typedef enum logic [1:0] {
    S_WAIT_INIT,
    S_IDLE,
    S_ISSUE,
    S_WAIT_DONE
  } state_t;

  state_t            state_q, state_d;
  logic [1:0]        op_q, op_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [TMR_W-1:0]  timer_q, timer_d;
  logic [3:0]        pend_q, pend_d;

  logic ref_tick;
  logic ref_done;
  logic accept;
  logic finish;
  logic rd_gnt_w;
  logic wr_gnt_w;
  logic force_wr;

  // handshake events; gated by rst so nothing pulses in the reset cycle
  assign accept   = (state_q == S_ISSUE) && bus_if.cmd_ready && !rst_i;
  assign finish   = (state_q == S_WAIT_DONE) && bus_if.cmd_done && !rst_i;
  assign rd_gnt_w = accept && (op_q == OP_RD);
  assign wr_gnt_w = accept && (op_q == OP_WR);
  assign ref_tick = init_done_i && (timer_q == '0);
  assign ref_done = finish && (op_q == OP_REF);

`ifdef DDR_ARB_STARVE_GUARD_EN
  localparam int               SC_W   = $clog2(STARVE_LIMIT + 1);
  localparam logic [SC_W-1:0]  SC_MAX = SC_W'(STARVE_LIMIT);

  logic [SC_W-1:0] starve_q, starve_d;

  // count consecutive read grants made while a write is waiting
  always_comb begin
    starve_d = starve_q;
    if (!bus_if.wr_req || wr_gnt_w) begin
      starve_d = '0;
    end else if (rd_gnt_w && (starve_q != SC_MAX)) begin
      starve_d = starve_q + 1'b1;
    end
  end

  // starvation counter register
  always_ff @(posedge clk133_p_i) begin
    if (rst_i) starve_q <= '0;
    else       starve_q <= starve_d;
  end

  assign force_wr = (starve_q == SC_MAX);
`else
  // never true: reads always outrank writes
  assign force_wr = (STARVE_LIMIT < 0);
`endif

  // refresh timer: counts down only while the DDR is initialised
  always_comb begin
    timer_d = timer_q;
    if (init_done_i) begin
      timer_d = (timer_q == '0) ? TMR_RELOAD : timer_q - 1'b1;
    end
  end

  // refresh debt: saturating add on tick, subtract on completed refresh, hold if both
  always_comb begin
    pend_d = pend_q;
    case ({ref_tick, ref_done})
      2'b10:   if (pend_q < PEND_MAX) pend_d = pend_q + 4'd1;
      2'b01:   if (pend_q != 4'd0)    pend_d = pend_q - 4'd1;
      default: pend_d = pend_q;
    endcase
  end

  // arbitration FSM: select in IDLE, hold the latched command until accepted
  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    case (state_q)
      S_WAIT_INIT: begin
        if (init_done_i) state_d = S_IDLE;
      end
      S_IDLE: begin
        if (!init_done_i) begin
          state_d = S_WAIT_INIT;
        end else if (pend_q == PEND_MAX) begin
          state_d = S_ISSUE;
          op_d    = OP_REF;
          addr_d  = '0;
          wdata_d = '0;
        end else if (bus_if.wr_req && force_wr) begin
          state_d = S_ISSUE;
          op_d    = OP_WR;
          addr_d  = bus_if.wr_addr;
          wdata_d = bus_if.wr_data;
        end else if (bus_if.rd_req) begin
          state_d = S_ISSUE;
          op_d    = OP_RD;
          addr_d  = bus_if.rd_addr;
          wdata_d = '0;
        end else if (bus_if.wr_req) begin
          state_d = S_ISSUE;
          op_d    = OP_WR;
          addr_d  = bus_if.wr_addr;
          wdata_d = bus_if.wr_data;
        end else if (pend_q != 4'd0) begin
          state_d = S_ISSUE;
          op_d    = OP_REF;
          addr_d  = '0;
          wdata_d = '0;
        end
      end
      S_ISSUE: begin
        if (bus_if.cmd_ready) state_d = S_WAIT_DONE;
      end
      S_WAIT_DONE: begin
        if (bus_if.cmd_done) state_d = init_done_i ? S_IDLE : S_WAIT_INIT;
      end
      default: state_d = S_WAIT_INIT;
    endcase
  end

  // state, latched command, timer and debt registers
  always_ff @(posedge clk133_p_i) begin
    if (rst_i) begin
      state_q <= S_WAIT_INIT;
      op_q    <= OP_RD;
      addr_q  <= '0;
      wdata_q <= '0;
      timer_q <= TMR_RELOAD;
      pend_q  <= 4'd0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      timer_q <= timer_d;
      pend_q  <= pend_d;
    end
  end

  assign bus_if.cmd_valid = (state_q == S_ISSUE);
  assign bus_if.cmd_op    = op_q;
  assign bus_if.cmd_addr  = addr_q;
  assign bus_if.cmd_wdata = wdata_q;
  assign bus_if.rd_gnt    = rd_gnt_w;
  assign bus_if.wr_gnt    = wr_gnt_w;
  assign bus_if.rd_done   = finish && (op_q == OP_RD);
  assign bus_if.wr_done   = finish && (op_q == OP_WR);
  assign ref_pend_o       = pend_q;

endmodule

// File: tb/tb_ddr_request_arbiter.sv
// tb/tb_ddr_request_arbiter.sv - directed self-checking bench for ddr_request_arbiter
module tb_ddr_request_arbiter;

  logic       clk = 1'b0;
  logic       rst;
  logic       init_done;
  logic [3:0] ref_pend;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  ddr_request_arbiter_if #(.ADDR_W(24), .DATA_W(32)) bus ();

  ddr_request_arbiter dut (
    .clk133_p_i  (clk),
    .rst_i       (rst),
    .init_done_i (init_done),
    .bus_if      (bus),
    .ref_pend_o  (ref_pend)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
    cyc++;
  endtask

  initial begin
    logic       seen_valid;
    logic       seen_gnt;
    logic [3:0] max_pend;
    int         n_rd;
    int         n_wr;
    int         n_gnt;
    int         first_wr;

    rst           = 1'b1;
    init_done     = 1'b0;
    bus.rd_req    = 1'b0;
    bus.rd_addr   = '0;
    bus.wr_req    = 1'b0;
    bus.wr_addr   = '0;
    bus.wr_data   = '0;
    bus.cmd_ready = 1'b0;
    bus.cmd_done  = 1'b0;

    // reset
    tick();
    tick();
    check("rst_cmd_valid", 64'(bus.cmd_valid), 64'd0);
    check("rst_ref_pend", 64'(ref_pend), 64'd0);
    check("rst_cmd_op", 64'(bus.cmd_op), 64'd0);
    check("rst_cmd_addr", 64'(bus.cmd_addr), 64'd0);

    // held off while init is not done
    rst         = 1'b0;
    bus.rd_req  = 1'b1;
    bus.rd_addr = 24'h00ABCD;
    seen_valid  = 1'b0;
    seen_gnt    = 1'b0;
    for (int i = 0; i < 100; i++) begin
      tick();
      seen_valid |= bus.cmd_valid;
      seen_gnt   |= bus.rd_gnt;
    end
    check("noinit_valid", 64'(seen_valid), 64'd0);
    check("noinit_gnt", 64'(seen_gnt), 64'd0);
    check("noinit_pend", 64'(ref_pend), 64'd0);

    // single read
    init_done     = 1'b1;
    bus.cmd_ready = 1'b1;
    cyc           = 0;
    tick();
    check("rd_idle_valid", 64'(bus.cmd_valid), 64'd0);
    tick();
    check("rd_valid", 64'(bus.cmd_valid), 64'd1);
    check("rd_op", 64'(bus.cmd_op), 64'd0);
    check("rd_addr", 64'(bus.cmd_addr), 64'h00ABCD);
    check("rd_gnt", 64'(bus.rd_gnt), 64'd1);
    bus.rd_req = 1'b0;
    tick();
    check("rd_wait_valid", 64'(bus.cmd_valid), 64'd0);
    check("rd_wait_gnt", 64'(bus.rd_gnt), 64'd0);
    bus.cmd_done = 1'b1;
    #1;
    check("rd_done", 64'(bus.rd_done), 64'd1);
    tick();
    bus.cmd_done = 1'b0;
    #1;
    check("rd_done_clear", 64'(bus.rd_done), 64'd0);

    // read and write together: read first, then write
    bus.rd_req  = 1'b1;
    bus.rd_addr = 24'h000100;
    bus.wr_req  = 1'b1;
    bus.wr_addr = 24'h000200;
    bus.wr_data = 32'hDEADBEEF;
    tick();
    check("rw_first_op", 64'(bus.cmd_op), 64'd0);
    check("rw_first_addr", 64'(bus.cmd_addr), 64'h000100);
    check("rw_first_wdata", 64'(bus.cmd_wdata), 64'd0);
    check("rw_first_rdgnt", 64'(bus.rd_gnt), 64'd1);
    check("rw_first_wrgnt", 64'(bus.wr_gnt), 64'd0);
    bus.rd_req = 1'b0;
    tick();
    tick();
    tick();
    bus.cmd_done = 1'b1;
    #1;
    check("rw_rd_done", 64'(bus.rd_done), 64'd1);
    tick();
    bus.cmd_done = 1'b0;
    check("rw_bubble_valid", 64'(bus.cmd_valid), 64'd0);
    tick();
    check("rw_wr_valid", 64'(bus.cmd_valid), 64'd1);
    check("rw_wr_op", 64'(bus.cmd_op), 64'd1);
    check("rw_wr_addr", 64'(bus.cmd_addr), 64'h000200);
    check("rw_wr_wdata", 64'(bus.cmd_wdata), 64'hDEADBEEF);
    check("rw_wr_gnt", 64'(bus.wr_gnt), 64'd1);
    bus.wr_req = 1'b0;
    tick();
    tick();
    tick();
    bus.cmd_done = 1'b1;
    #1;
    check("rw_wr_done", 64'(bus.wr_done), 64'd1);
    check("rw_wr_rd_done", 64'(bus.rd_done), 64'd0);
    tick();
    bus.cmd_done = 1'b0;

    // first periodic refresh
    while (cyc < 1039) tick();
    check("ref_pend_before", 64'(ref_pend), 64'd0);
    tick();
    check("ref_pend_one", 64'(ref_pend), 64'd1);
    check("ref_idle_valid", 64'(bus.cmd_valid), 64'd0);
    tick();
    check("ref_valid", 64'(bus.cmd_valid), 64'd1);
    check("ref_op", 64'(bus.cmd_op), 64'd2);
    check("ref_addr", 64'(bus.cmd_addr), 64'd0);
    check("ref_wdata", 64'(bus.cmd_wdata), 64'd0);
    check("ref_no_gnt", 64'({bus.rd_gnt, bus.wr_gnt}), 64'd0);
    tick();
    bus.cmd_done = 1'b1;
    #1;
    check("ref_no_done", 64'({bus.rd_done, bus.wr_done}), 64'd0);
    tick();
    bus.cmd_done = 1'b0;
    check("ref_pend_zero", 64'(ref_pend), 64'd0);

    // stalled read while refresh debt saturates
    bus.cmd_ready = 1'b0;
    bus.rd_req    = 1'b1;
    bus.rd_addr   = 24'h123456;
    max_pend      = 4'd0;
    while (cyc < 10500) begin
      tick();
      if (ref_pend > max_pend) max_pend = ref_pend;
    end
    check("sat_max_pend", 64'(max_pend), 64'd8);
    check("sat_pend", 64'(ref_pend), 64'd8);
    check("sat_valid", 64'(bus.cmd_valid), 64'd1);
    check("sat_addr", 64'(bus.cmd_addr), 64'h123456);
    bus.cmd_ready = 1'b1;
    #1;
    check("sat_rd_gnt", 64'(bus.rd_gnt), 64'd1);
    tick();
    bus.cmd_done = 1'b1;
    #1;
    check("sat_rd_done", 64'(bus.rd_done), 64'd1);
    tick();
    bus.cmd_done = 1'b0;
    tick();
    check("sat_ref_op", 64'(bus.cmd_op), 64'd2);
    check("sat_ref_valid", 64'(bus.cmd_valid), 64'd1);
    check("sat_ref_no_gnt", 64'(bus.rd_gnt), 64'd0);
    tick();
    bus.cmd_done = 1'b1;
    tick();
    bus.cmd_done = 1'b0;
    check("sat_pend_seven", 64'(ref_pend), 64'd7);
    tick();
    check("sat_then_rd_op", 64'(bus.cmd_op), 64'd0);
    check("sat_then_rd_gnt", 64'(bus.rd_gnt), 64'd1);
    tick();
    bus.rd_req   = 1'b0;
    bus.cmd_done = 1'b1;
    tick();
    bus.cmd_done = 1'b0;
    tick();
    check("drain_ref_op", 64'(bus.cmd_op), 64'd2);
    tick();
    bus.cmd_done = 1'b1;
    tick();
    bus.cmd_done = 1'b0;
    check("drain_pend_six", 64'(ref_pend), 64'd6);

    // read and write held high continuously
    bus.rd_req    = 1'b1;
    bus.rd_addr   = 24'h000300;
    bus.wr_req    = 1'b1;
    bus.wr_addr   = 24'h000400;
    bus.wr_data   = 32'h0000CAFE;
    bus.cmd_done  = 1'b1;
    n_rd          = 0;
    n_wr          = 0;
    n_gnt         = 0;
    first_wr      = -1;
    for (int i = 0; i < 200; i++) begin
      tick();
      if (bus.rd_gnt) begin
        n_rd++;
        n_gnt++;
      end
      if (bus.wr_gnt) begin
        if (first_wr < 0) first_wr = n_gnt;
        n_wr++;
        n_gnt++;
      end
    end
`ifdef DDR_ARB_STARVE_GUARD_EN
    check("starve_reads", 64'(n_rd), 64'd64);
    check("starve_writes", 64'(n_wr), 64'd3);
    check("starve_first_wr", 64'(first_wr), 64'd16);
`else
    check("strict_reads", 64'(n_rd), 64'd67);
    check("strict_writes", 64'(n_wr), 64'd0);
`endif

    // reset in the middle of a command
    bus.cmd_ready = 1'b0;
    bus.wr_req    = 1'b0;
    for (int i = 0; i < 10 && !bus.cmd_valid; i++) tick();
    check("pre_rst_valid", 64'(bus.cmd_valid), 64'd1);
    bus.cmd_done  = 1'b0;
    rst           = 1'b1;
    bus.cmd_ready = 1'b1;
    #1;
    check("rst_cycle_no_gnt", 64'({bus.rd_gnt, bus.wr_gnt}), 64'd0);
    tick();
    check("mid_rst_valid", 64'(bus.cmd_valid), 64'd0);
    check("mid_rst_pend", 64'(ref_pend), 64'd0);
    check("mid_rst_op", 64'(bus.cmd_op), 64'd0);
    check("mid_rst_wdata", 64'(bus.cmd_wdata), 64'd0);
    check("mid_rst_gnt", 64'({bus.rd_gnt, bus.wr_gnt}), 64'd0);

    // init_done drops while a command is outstanding
    rst         = 1'b0;
    bus.rd_req  = 1'b1;
    bus.rd_addr = 24'h0000AA;
    tick();
    check("drop_idle_valid", 64'(bus.cmd_valid), 64'd0);
    tick();
    check("drop_valid", 64'(bus.cmd_valid), 64'd1);
    check("drop_rd_gnt", 64'(bus.rd_gnt), 64'd1);
    init_done  = 1'b0;
    bus.rd_req = 1'b0;
    tick();
    bus.cmd_done = 1'b1;
    #1;
    check("drop_rd_done", 64'(bus.rd_done), 64'd1);
    tick();
    bus.cmd_done = 1'b0;
    bus.rd_req   = 1'b1;
    seen_valid   = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      seen_valid |= bus.cmd_valid;
    end
    check("drop_held_valid", 64'(seen_valid), 64'd0);
    check("drop_held_pend", 64'(ref_pend), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
